fc_mac_sequencer: RTL and testbench
===================================

# fc_mac_sequencer

Sequencer for the 20-lane fully-connected multiplier-accumulator. It streams one 20-element chunk per cycle from the input-activation SRAM and the weight SRAM, and aligns the two reads to the MAC's internal weight register. It drives the MAC's accumulate_reset at each neuron boundary. It captures each finished neuron sum, applies ReLU, shift and saturation, and emits one 8-bit activation per output neuron to the next layer's buffer.

## Interface
Parameters:
- IN_CHUNKS, 40, number of 20-element chunks per output neuron (800 inputs).
- OUT_NUM, 500, number of output neurons per layer run.
- SHIFT, 8, arithmetic right shift applied to the neuron sum before saturation.
- WADDR_W, 15, weight SRAM address width; must hold OUT_NUM*IN_CHUNKS-1.
- IADDR_W, 6, input SRAM address width; must hold IN_CHUNKS-1.
- OIDX_W, 9, output index width; must hold OUT_NUM-1.

Ports:
- clk, in, 1, clock.
- srstn, in, 1, reset, synchronous, active-low.
- start, in, 1, run request; sampled only while busy=0.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse at end of run.
- sram_ren_weight, out, 1, weight SRAM read enable.
- sram_raddr_weight, out, WADDR_W, weight chunk address.
- sram_ren_input, out, 1, input SRAM read enable.
- sram_raddr_input, out, IADDR_W, input chunk address.
- accumulate_reset, out, 1, to MAC; restarts accumulation.
- mac_data_out, in, 23 signed, MAC accumulator output.
- out_valid, out, 1, one finished neuron on out_* this cycle.
- out_index, out, OIDX_W, neuron number n.
- out_raw, out, 23 signed, unquantized neuron sum.
- out_data, out, 8, quantized activation, range 0..127.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE when start=1.
  - ISSUE -> DRAIN after global chunk j = OUT_NUM*IN_CHUNKS-1 is issued.
  - DRAIN -> IDLE once the last out_valid has been produced; done pulses on that transition cycle.
- Global chunk counter j: neuron n = j / IN_CHUNKS, chunk k = j mod IN_CHUNKS. Implement with separate n and k counters; no divider.
- Weight address = j, a linear counter with no multiplier. Input address = k.
- Pipeline tracking: 3-stage valid shift register carrying {first (k==0), last (k==IN_CHUNKS-1), n}.
- Quantization:
  - If out_raw < 0, out_data = 0.
  - Otherwise v = out_raw >>> SHIFT; out_data = min(v, 127).
- start is ignored while busy=1.
- IN_CHUNKS=1 is legal: every chunk is both first and last, so accumulate_reset and out_valid are high every active cycle.

## Timing
- Let c be the issue cycle of chunk j.
- Cycle c: sram_ren_weight=1, sram_raddr_weight=j.
- Cycle c+1: sram_ren_input=1, sram_raddr_input=k. This is a one-cycle input delay that matches the MAC's registered weight path.
- Cycle c+2: both operands are at the MAC; accumulate_reset=1 if k==0.
  - accumulate_reset is also 1 whenever stage 2 holds no valid chunk, which keeps the MAC sum bounded while idle.
- Cycle c+3: if k==IN_CHUNKS-1, out_valid=1, out_raw=mac_data_out, out_data=quantized value, out_index=n.
  - out_* are combinational from mac_data_out and the stage-3 flags; out_valid is a one-cycle strobe.
- start sampled at cycle S:
  - Chunk j is issued at S+1+j, with no bubbles.
  - busy is 1 from S+1 through the done cycle.
  - The final out_valid occurs at S+N+3, where N = OUT_NUM*IN_CHUNKS.
  - done occurs at S+N+4.
  - start may be accepted again at S+N+5.
- Reset values:
  - busy, done, out_valid, both ren signals = 0.
  - Both addresses, out_index = 0.
  - accumulate_reset = 1.
  - Pipeline flags cleared; FSM in IDLE.
- Reset mid-run: all outputs return to reset values on the next edge. No out_valid or done is issued for the aborted run.
- Read enables are low outside issue slots. Addresses hold their last value.

## Test plan
- IN_CHUNKS=4, OUT_NUM=2, SHIFT=0; all inputs 1, all weights 1:
  - out_valid at S+7 and S+11 with out_raw=80, out_data=80, index 0 then 1.
  - done at S+12.
- Same configuration with all weights -1 -> out_raw=-80, out_data=0.
- Inputs 127, weights 7, IN_CHUNKS=4, SHIFT=8 -> out_raw=71120, out_data=127 (saturated).
- IN_CHUNKS=1, OUT_NUM=3 -> accumulate_reset high every cycle; out_valid at S+4, S+5, S+6; done at S+7.
- start pulsed while busy is ignored. srstn asserted mid-run clears all outputs, and no done follows. A fresh start then completes normally.
- Address check for IN_CHUNKS=4, OUT_NUM=2:
  - Weight addresses 0..7, consecutive, starting at S+1.
  - Input addresses 0,1,2,3,0,1,2,3, each one cycle after its weight address.

Source files
------------

// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer: sequencer for the 20-lane fully-connected MAC.
// Walks every (neuron, chunk) pair once per run. It issues weight reads
// linearly and input reads one cycle later, so both operands reach the MAC
// together with its registered weight path. It pulses accumulate_reset at
// each neuron boundary. It quantizes each finished neuron sum with ReLU,
// an arithmetic shift and saturation to 0..127.
// Ports:
//   clk, srstn             clock, synchronous active-low reset
//   start / busy / done    run handshake (start ignored while busy)
//   sram_ren_weight/_raddr_weight  weight chunk read, address = global chunk j
//   sram_ren_input/_raddr_input    input chunk read, address = chunk k
//   accumulate_reset       restarts MAC accumulation
//   mac_data_out           MAC accumulator value
//   out_valid/out_index/out_raw/out_data  finished neuron strobe and payload
module fc_mac_sequencer #(
  parameter int unsigned IN_CHUNKS = 40,
  parameter int unsigned OUT_NUM   = 500,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned WADDR_W   = 15,
  parameter int unsigned IADDR_W   = 6,
  parameter int unsigned OIDX_W    = 9
) (
  input  logic                      clk,
  input  logic                      srstn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      sram_ren_weight,
  output logic [WADDR_W-1:0]        sram_raddr_weight,
  output logic                      sram_ren_input,
  output logic [IADDR_W-1:0]        sram_raddr_input,
  output logic                      accumulate_reset,
  input  logic signed [22:0]        mac_data_out,
  output logic                      out_valid,
  output logic [OIDX_W-1:0]         out_index,
  output logic signed [22:0]        out_raw,
  output logic [7:0]                out_data
);

  localparam int unsigned ACC_W = 23;
  localparam logic [IADDR_W-1:0] K_LAST = IADDR_W'(IN_CHUNKS - 1);
  localparam logic [OIDX_W-1:0]  N_LAST = OIDX_W'(OUT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_d;

  // Chunk counters for the chunk being issued this cycle
  logic [IADDR_W-1:0] k, k_d;
  logic [OIDX_W-1:0]  n, n_d;

  logic               ren_w_d;
  logic [WADDR_W-1:0] waddr_d;
  logic               done_d;
  logic               busy_d;

  // Pipeline stages 1..3 following the issue cycle
  logic              s1_v, s1_first, s1_last;
  logic [OIDX_W-1:0] s1_n;
  logic              s2_v, s2_last;
  logic [OIDX_W-1:0] s2_n;
  logic              s3_v, s3_last;
  logic [OIDX_W-1:0] s3_n;

  logic final_out_c;
  logic signed [ACC_W-1:0] shifted_c;

  assign final_out_c = s3_v && s3_last && (s3_n == N_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!srstn) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and next values of the issue-side registers
  always_comb begin
    state_d = state;
    ren_w_d = 1'b0;
    waddr_d = sram_raddr_weight;
    k_d     = k;
    n_d     = n;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          ren_w_d = 1'b1;
          waddr_d = '0;
          k_d     = '0;
          n_d     = '0;
        end
      end
      ISSUE: begin
        if (k == K_LAST && n == N_LAST) begin
          state_d = DRAIN;
        end else begin
          ren_w_d = 1'b1;
          waddr_d = sram_raddr_weight + WADDR_W'(1);
          if (k == K_LAST) begin
            k_d = '0;
            n_d = n + OIDX_W'(1);
          end else begin
            k_d = k + IADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        // done is held for one cycle; leave DRAIN on that cycle
        if (done)             state_d = IDLE;
        else if (final_out_c) done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Issue registers, read pipeline and handshake outputs
  always_ff @(posedge clk) begin
    if (!srstn) begin
      k                 <= '0;
      n                 <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      sram_ren_weight   <= 1'b0;
      sram_raddr_weight <= '0;
      sram_ren_input    <= 1'b0;
      sram_raddr_input  <= '0;
      accumulate_reset  <= 1'b1;
      s1_v              <= 1'b0;
      s1_first          <= 1'b0;
      s1_last           <= 1'b0;
      s1_n              <= '0;
      s2_v              <= 1'b0;
      s2_last           <= 1'b0;
      s2_n              <= '0;
      s3_v              <= 1'b0;
      s3_last           <= 1'b0;
      s3_n              <= '0;
    end else begin
      k                 <= k_d;
      n                 <= n_d;
      busy              <= busy_d;
      done              <= done_d;
      sram_ren_weight   <= ren_w_d;
      sram_raddr_weight <= waddr_d;
      // Input read trails the weight read by one cycle
      sram_ren_input    <= sram_ren_weight;
      if (sram_ren_weight) sram_raddr_input <= k;
      s1_v              <= sram_ren_weight;
      s1_first          <= (k == '0);
      s1_last           <= (k == K_LAST);
      s1_n              <= n;
      // Registered from stage 1 so it is aligned with stage 2 (operands at MAC)
      accumulate_reset  <= !s1_v || s1_first;
      s2_v              <= s1_v;
      s2_last           <= s1_last;
      s2_n              <= s1_n;
      s3_v              <= s2_v;
      s3_last           <= s2_last;
      s3_n              <= s2_n;
    end
  end

  // Finished-neuron output: ReLU, shift, saturate to 0..127
  always_comb begin
    out_valid = s3_v && s3_last;
    out_index = s3_n;
    out_raw   = '0;
    out_data  = '0;
    shifted_c = mac_data_out >>> SHIFT;
    if (out_valid) begin
      out_raw = mac_data_out;
      if (!mac_data_out[ACC_W-1]) begin
        if (|shifted_c[ACC_W-1:7]) out_data = 8'd127;
        else                       out_data = {1'b0, shifted_c[6:0]};
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
module tb_fc_mac_sequencer;

  typedef struct {
    int cyc;
    int idx;
    int raw;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic srstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: IN_CHUNKS=4, OUT_NUM=2, SHIFT=0
  logic              start_a, busy_a, done_a, ren_w_a, ren_i_a, acc_rst_a, out_valid_a;
  logic [2:0]        waddr_a;
  logic [1:0]        iaddr_a;
  logic [0:0]        out_index_a;
  logic signed [22:0] mac_a, out_raw_a;
  logic [7:0]        out_data_a;

  fc_mac_sequencer #(
    .IN_CHUNKS(4), .OUT_NUM(2), .SHIFT(0), .WADDR_W(3), .IADDR_W(2), .OIDX_W(1)
  ) dut_a (
    .clk(clk), .srstn(srstn), .start(start_a), .busy(busy_a), .done(done_a),
    .sram_ren_weight(ren_w_a), .sram_raddr_weight(waddr_a),
    .sram_ren_input(ren_i_a), .sram_raddr_input(iaddr_a),
    .accumulate_reset(acc_rst_a), .mac_data_out(mac_a),
    .out_valid(out_valid_a), .out_index(out_index_a), .out_raw(out_raw_a),
    .out_data(out_data_a)
  );

  // Instance C: IN_CHUNKS=1, OUT_NUM=3, SHIFT=8
  logic              start_c, busy_c, done_c, ren_w_c, ren_i_c, acc_rst_c, out_valid_c;
  logic [1:0]        waddr_c;
  logic [0:0]        iaddr_c;
  logic [1:0]        out_index_c;
  logic signed [22:0] mac_c, out_raw_c;
  logic [7:0]        out_data_c;

  fc_mac_sequencer #(
    .IN_CHUNKS(1), .OUT_NUM(3), .SHIFT(8), .WADDR_W(2), .IADDR_W(1), .OIDX_W(2)
  ) dut_c (
    .clk(clk), .srstn(srstn), .start(start_c), .busy(busy_c), .done(done_c),
    .sram_ren_weight(ren_w_c), .sram_raddr_weight(waddr_c),
    .sram_ren_input(ren_i_c), .sram_raddr_input(iaddr_c),
    .accumulate_reset(acc_rst_c), .mac_data_out(mac_c),
    .out_valid(out_valid_c), .out_index(out_index_c), .out_raw(out_raw_c),
    .out_data(out_data_c)
  );

  // SRAM contents: one value per chunk, replicated across the 20 lanes
  int imem_a [4];
  int wmem_a [8];
  int imem_c [2];
  int wmem_c [4];

  // Behavioral SRAMs (1-cycle read) + MAC with a registered weight stage
  int wq_a, wreg_a, iq_a, acc_a;
  always @(posedge clk) begin
    if (ren_w_a) wq_a <= wmem_a[waddr_a];
    wreg_a <= wq_a;
    if (ren_i_a) iq_a <= imem_a[iaddr_a];
    acc_a <= (acc_rst_a ? 0 : acc_a) + 20 * iq_a * wreg_a;
  end
  assign mac_a = 23'(acc_a);

  int wq_c, wreg_c, iq_c, acc_c;
  always @(posedge clk) begin
    if (ren_w_c) wq_c <= wmem_c[waddr_c];
    wreg_c <= wq_c;
    if (ren_i_c) iq_c <= imem_c[iaddr_c];
    acc_c <= (acc_rst_c ? 0 : acc_c) + 20 * iq_c * wreg_c;
  end
  assign mac_c = 23'(acc_c);

  exp_t sb_a[$];
  exp_t sb_c[$];

  function automatic int quant(input int raw, input int sh);
    int v;
    if (raw < 0) return 0;
    v = raw >>> sh;
    return (v > 127) ? 127 : v;
  endfunction

  // Output monitors: pop expected neuron results
  always @(negedge clk) begin
    if (out_valid_a === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_out cyc=%0d idx=%0d raw=%0d", cyc, out_index_a, out_raw_a);
      end else begin
        e = sb_a.pop_front();
        if (cyc !== e.cyc) begin
          errors++; $display("FAIL a_out_cycle got %0d exp %0d", cyc, e.cyc);
        end
        checks++;
        if (int'(out_index_a) !== e.idx) begin
          errors++; $display("FAIL a_out_index got %0d exp %0d", out_index_a, e.idx);
        end
        checks++;
        if (int'(out_raw_a) !== e.raw) begin
          errors++; $display("FAIL a_out_raw got %0d exp %0d", out_raw_a, e.raw);
        end
        checks++;
        if (int'(out_data_a) !== e.data) begin
          errors++; $display("FAIL a_out_data got %0d exp %0d", out_data_a, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_c === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_c.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected_out cyc=%0d idx=%0d raw=%0d", cyc, out_index_c, out_raw_c);
      end else begin
        e = sb_c.pop_front();
        if (cyc !== e.cyc) begin
          errors++; $display("FAIL c_out_cycle got %0d exp %0d", cyc, e.cyc);
        end
        checks++;
        if (int'(out_index_c) !== e.idx) begin
          errors++; $display("FAIL c_out_index got %0d exp %0d", out_index_c, e.idx);
        end
        checks++;
        if (int'(out_raw_c) !== e.raw) begin
          errors++; $display("FAIL c_out_raw got %0d exp %0d", out_raw_c, e.raw);
        end
        checks++;
        if (int'(out_data_c) !== e.data) begin
          errors++; $display("FAIL c_out_data got %0d exp %0d", out_data_c, e.data);
        end
      end
    end
  end

  // One run on instance A with per-cycle handshake/address checks;
  // poke=1 pulses start while busy, which must have no effect
  task automatic run_a(input bit poke);
    int s, raw;
    @(negedge clk);
    start_a = 1'b1;
    s = cyc;
    for (int nn = 0; nn < 2; nn++) begin
      raw = 0;
      for (int kk = 0; kk < 4; kk++) raw += 20 * imem_a[kk] * wmem_a[nn*4 + kk];
      sb_a.push_back('{s + 3 + 4*(nn+1), nn, raw, quant(raw, 0)});
    end
    for (int t = 1; t <= 14; t++) begin
      bit exp_ren_w, exp_ren_i, exp_acc, exp_done, exp_busy;
      int exp_wa, exp_ia;
      @(negedge clk);
      start_a = poke && (t == 3);
      exp_ren_w = (t >= 1 && t <= 8);
      exp_wa    = (t <= 8) ? t - 1 : 7;
      exp_ren_i = (t >= 2 && t <= 9);
      exp_ia    = (t <= 9) ? (t - 2) % 4 : 3;
      exp_acc   = (t >= 3 && t <= 10) ? ((t - 3) % 4 == 0) : 1'b1;
      exp_done  = (t == 12);
      exp_busy  = (t >= 1 && t <= 12);
      checks++;
      if (ren_w_a !== exp_ren_w) begin
        errors++; $display("FAIL a_ren_weight t=%0d got %0b exp %0b", t, ren_w_a, exp_ren_w);
      end
      checks++;
      if (int'(waddr_a) !== exp_wa) begin
        errors++; $display("FAIL a_raddr_weight t=%0d got %0d exp %0d", t, waddr_a, exp_wa);
      end
      checks++;
      if (ren_i_a !== exp_ren_i) begin
        errors++; $display("FAIL a_ren_input t=%0d got %0b exp %0b", t, ren_i_a, exp_ren_i);
      end
      if (t >= 2) begin
        checks++;
        if (int'(iaddr_a) !== exp_ia) begin
          errors++; $display("FAIL a_raddr_input t=%0d got %0d exp %0d", t, iaddr_a, exp_ia);
        end
      end
      checks++;
      if (acc_rst_a !== exp_acc) begin
        errors++; $display("FAIL a_acc_reset t=%0d got %0b exp %0b", t, acc_rst_a, exp_acc);
      end
      checks++;
      if (done_a !== exp_done) begin
        errors++; $display("FAIL a_done t=%0d got %0b exp %0b", t, done_a, exp_done);
      end
      checks++;
      if (busy_a !== exp_busy) begin
        errors++; $display("FAIL a_busy t=%0d got %0b exp %0b", t, busy_a, exp_busy);
      end
    end
    start_a = 1'b0;
    checks++;
    if (sb_a.size() != 0) begin
      errors++; $display("FAIL a_missing_outputs got %0d pending exp 0", sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, out_valid_a, ren_w_a, ren_i_a} !== 5'b0) begin
      errors++; $display("FAIL reset_a_flags got %b exp 00000", {busy_a, done_a, out_valid_a, ren_w_a, ren_i_a});
    end
    checks++;
    if ({waddr_a, iaddr_a, out_index_a} !== 6'b0) begin
      errors++; $display("FAIL reset_a_addr got %b exp 000000", {waddr_a, iaddr_a, out_index_a});
    end
    checks++;
    if (acc_rst_a !== 1'b1) begin
      errors++; $display("FAIL reset_a_acc_reset got %b exp 1", acc_rst_a);
    end
    checks++;
    if ({busy_c, done_c, out_valid_c, ren_w_c, ren_i_c} !== 5'b0) begin
      errors++; $display("FAIL reset_c_flags got %b exp 00000", {busy_c, done_c, out_valid_c, ren_w_c, ren_i_c});
    end
    checks++;
    if (acc_rst_c !== 1'b1) begin
      errors++; $display("FAIL reset_c_acc_reset got %b exp 1", acc_rst_c);
    end
    srstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    for (int i = 0; i < 4; i++) imem_a[i] = 1;
    for (int i = 0; i < 8; i++) wmem_a[i] = 1;
    run_a(1'b0);
  endtask

  task automatic test_negative();
    for (int i = 0; i < 8; i++) wmem_a[i] = -1;
    run_a(1'b0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) imem_a[i] = 127;
    for (int i = 0; i < 8; i++) wmem_a[i] = 7;
    run_a(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) imem_a[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 8; i++) wmem_a[i] = int'($urandom_range(0, 15)) - 8;
      run_a(1'b0);
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 4; i++) imem_a[i] = i + 1;
    for (int i = 0; i < 8; i++) wmem_a[i] = 3 - i;
    run_a(1'b1);
  endtask

  task automatic test_one_chunk();
    int s, raw;
    imem_c[0] = 100;
    wmem_c[0] = 7;
    wmem_c[1] = -3;
    wmem_c[2] = 50;
    @(negedge clk);
    start_c = 1'b1;
    s = cyc;
    for (int nn = 0; nn < 3; nn++) begin
      raw = 20 * imem_c[0] * wmem_c[nn];
      sb_c.push_back('{s + 4 + nn, nn, raw, quant(raw, 8)});
    end
    for (int t = 1; t <= 9; t++) begin
      bit exp_ren_w, exp_ren_i, exp_done, exp_busy;
      int exp_wa;
      @(negedge clk);
      start_c = 1'b0;
      exp_ren_w = (t >= 1 && t <= 3);
      exp_wa    = (t <= 3) ? t - 1 : 2;
      exp_ren_i = (t >= 2 && t <= 4);
      exp_done  = (t == 7);
      exp_busy  = (t >= 1 && t <= 7);
      checks++;
      if (ren_w_c !== exp_ren_w) begin
        errors++; $display("FAIL c_ren_weight t=%0d got %0b exp %0b", t, ren_w_c, exp_ren_w);
      end
      checks++;
      if (int'(waddr_c) !== exp_wa) begin
        errors++; $display("FAIL c_raddr_weight t=%0d got %0d exp %0d", t, waddr_c, exp_wa);
      end
      checks++;
      if (ren_i_c !== exp_ren_i) begin
        errors++; $display("FAIL c_ren_input t=%0d got %0b exp %0b", t, ren_i_c, exp_ren_i);
      end
      checks++;
      if (acc_rst_c !== 1'b1) begin
        errors++; $display("FAIL c_acc_reset t=%0d got %0b exp 1", t, acc_rst_c);
      end
      checks++;
      if (done_c !== exp_done) begin
        errors++; $display("FAIL c_done t=%0d got %0b exp %0b", t, done_c, exp_done);
      end
      checks++;
      if (busy_c !== exp_busy) begin
        errors++; $display("FAIL c_busy t=%0d got %0b exp %0b", t, busy_c, exp_busy);
      end
    end
    checks++;
    if (sb_c.size() != 0) begin
      errors++; $display("FAIL c_missing_outputs got %0d pending exp 0", sb_c.size());
      sb_c.delete();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) imem_a[i] = 2;
    for (int i = 0; i < 8; i++) wmem_a[i] = 5;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    srstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, out_valid_a, ren_w_a, ren_i_a} !== 5'b0) begin
      errors++; $display("FAIL midrst_flags got %b exp 00000", {busy_a, done_a, out_valid_a, ren_w_a, ren_i_a});
    end
    checks++;
    if ({waddr_a, iaddr_a, out_index_a} !== 6'b0) begin
      errors++; $display("FAIL midrst_addr got %b exp 000000", {waddr_a, iaddr_a, out_index_a});
    end
    checks++;
    if (acc_rst_a !== 1'b1) begin
      errors++; $display("FAIL midrst_acc_reset got %b exp 1", acc_rst_a);
    end
    srstn = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      checks++;
      if ({done_a, busy_a, ren_w_a} !== 3'b0) begin
        errors++; $display("FAIL midrst_quiet t=%0d got %b exp 000", t, {done_a, busy_a, ren_w_a});
      end
    end
    run_a(1'b0);
  endtask

  initial begin
    srstn   = 1'b0;
    start_a = 1'b0;
    start_c = 1'b0;
    test_reset();
    test_ones();
    test_negative();
    test_saturate();
    test_random();
    test_start_ignored();
    test_one_chunk();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
